// File: rtl/datawidthconv_narrow_to_wide.sv
// Narrow-to-wide read streamer: reads N*R words of IN_W bits from memory,
// packs each group of R words (first word in the LSBs) into one OUT_W beat
// and streams the beats through a buffered valid/ready source port.
module datawidthconv_narrow_to_wide #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 512,
  parameter int ADDR_W     = 32,
  parameter int ADDR_STEP  = 4,
  parameter int MAX_BEATS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           src_req,
  input  logic [ADDR_W-1:0]              req_base,
  input  logic [$clog2(MAX_BEATS+1)-1:0] req_beats,
  output logic [ADDR_W-1:0]              data_addr,
  output logic                           data_oe,
  input  logic [IN_W-1:0]                data_q,
  output logic                           src_valid,
  input  logic                           src_ready,
  output logic                           src_sop,
  output logic                           src_eop,
  output logic [OUT_W-1:0]               src_q,
  output logic                           busy,
  output logic                           done
);

  localparam int R      = OUT_W / IN_W;
  localparam int BC_W   = $clog2(MAX_BEATS + 1);
  localparam int RD_W   = $clog2(MAX_BEATS * R + 1);
  localparam int SLOT_W = $clog2(R);
  localparam int CAP    = FIFO_DEPTH + 1;   // FIFO entries plus the registered head
  localparam int PTR_W  = $clog2(CAP);
  localparam int CNT_W  = $clog2(CAP + 1);
  localparam int ENT_W  = OUT_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_req_d;
  logic [ADDR_W-1:0]     r_addr;
  logic [BC_W-1:0]       r_beats;
  logic [RD_W-1:0]       r_reads_left;
  logic [SLOT_W-1:0]     r_iss_slot;
  logic [SLOT_W-1:0]     r_cap_slot;
  logic                  r_cap_vld;
  logic [1:0]            r_pend;
  logic [BC_W-1:0]       r_push_idx;
  logic [OUT_W-IN_W-1:0] r_pack;
  logic [ENT_W-1:0]      r_mem [CAP];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_start, w_load, w_push, w_pop, w_start_ok;
  logic [BC_W-1:0]       w_n_eff;
  logic [CNT_W-1:0]      w_occ;
  logic [ENT_W-1:0]      w_entry;

  assign w_start = src_req && !r_req_d;
  assign w_load  = w_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_n_eff = (req_beats == '0 || req_beats > BC_W'(MAX_BEATS)) ? BC_W'(MAX_BEATS) : req_beats;

  // Space is reserved a whole beat at a time: a new beat may start only if the
  // FIFO behind the head plus beats already started but not yet pushed leaves
  // a free entry. Once started, a beat's reads run to completion.
  assign w_occ      = (r_count == '0) ? '0 : r_count - CNT_W'(1);
  assign w_start_ok = (32'(w_occ) + 32'(r_pend)) < 32'(FIFO_DEPTH);
  assign data_oe    = (r_state == S_FETCH) && (r_reads_left != '0) &&
                      ((r_iss_slot != '0) || w_start_ok);
  assign data_addr  = r_addr;

  assign w_push  = r_cap_vld && (r_cap_slot == SLOT_W'(R - 1));
  assign w_pop   = src_valid && src_ready;
  assign w_entry = {(r_push_idx == '0), (r_push_idx == r_beats - BC_W'(1)), data_q, r_pack};

  assign src_valid = (r_count != '0);
  assign {src_sop, src_eop, src_q} = r_mem[r_rd_ptr];
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // State register and request edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_req_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_d <= src_req;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
      S_FETCH: if (data_oe && r_reads_left == RD_W'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && src_eop) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_start ? S_FETCH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read issue: address, remaining reads, slot of next read, started beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr       <= '0;
      r_beats      <= '0;
      r_reads_left <= '0;
      r_iss_slot   <= '0;
      r_pend       <= '0;
    end else begin
      if (w_load) begin
        r_addr       <= req_base;
        r_beats      <= w_n_eff;
        r_reads_left <= RD_W'(w_n_eff) * RD_W'(R);
        r_iss_slot   <= '0;
      end else if (data_oe) begin
        r_addr       <= r_addr + ADDR_W'(ADDR_STEP);
        r_reads_left <= r_reads_left - RD_W'(1);
        r_iss_slot   <= (r_iss_slot == SLOT_W'(R - 1)) ? '0 : r_iss_slot + SLOT_W'(1);
      end
      unique case ({data_oe && r_iss_slot == '0, w_push})
        2'b10:   r_pend <= r_pend + 2'd1;
        2'b01:   r_pend <= r_pend - 2'd1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  // Read-data capture into the pack buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_vld  <= 1'b0;
      r_cap_slot <= '0;
      r_push_idx <= '0;
      r_pack     <= '0;
    end else begin
      r_cap_vld <= data_oe;
      if (w_load) begin
        r_cap_slot <= '0;
        r_push_idx <= '0;
      end else if (r_cap_vld) begin
        r_cap_slot <= (r_cap_slot == SLOT_W'(R - 1)) ? '0 : r_cap_slot + SLOT_W'(1);
        for (int unsigned k = 0; k < R - 1; k++) begin
          if (r_cap_slot == SLOT_W'(k)) r_pack[IN_W*k +: IN_W] <= data_q;
        end
        if (w_push) r_push_idx <= r_push_idx + BC_W'(1);
      end
    end
  end

  // Beat FIFO with registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CAP; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= (r_wr_ptr == PTR_W'(CAP - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(CAP - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule
